// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame geometry used by the
// transmitter and the receiver on the same serial link.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned OS_CNT_W        = 4;
  localparam int unsigned BIT_IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/uart_tx_tick_gen.sv
// Free-running tick generator: one-clk tick every TICK_LIMIT+1 clocks,
// synchronously restartable so a frame's bit timing is aligned to its accept.
module uart_tx_tick_gen #(
  parameter int unsigned TICK_LIMIT = 650
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TICK_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LIMIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to append an
// even-parity bit after the data bits (frame grows to 11 bit periods).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned TICK_LIMIT = 650,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           st
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned SHREG_W = DATA_BITS + PAR_BITS;
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS + PAR_BITS - 1);
  localparam logic [OS_CNT_W-1:0]  OS_LAST  = OS_CNT_W'(OVERSAMPLE - 1);

  uart_state_e          r_state;
  logic [SHREG_W-1:0]   r_shreg;
  logic [OS_CNT_W-1:0]  r_os_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  uart_state_e          w_state_nxt;
  logic [SHREG_W-1:0]   w_shreg_nxt;
  logic [SHREG_W-1:0]   w_shreg_load;
  logic [OS_CNT_W-1:0]  w_os_nxt;
  logic [BIT_IDX_W-1:0] w_bit_nxt;
  logic                 w_tx_nxt;
  logic                 w_done_nxt;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_bit_end;

  assign w_accept = send && r_ready;

  // Parity rides as the top shift-register bit so it falls out after the data.
`ifdef UART_TX_PARITY_EN
  assign w_shreg_load = {^data_in, data_in};
`else
  assign w_shreg_load = data_in;
`endif

  uart_tx_tick_gen #(
    .TICK_LIMIT(TICK_LIMIT)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(w_accept),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_idx;
    w_done_nxt  = 1'b0;
    w_tx_nxt    = 1'b1;
    w_bit_end   = w_tick && (r_os_cnt == OS_LAST);

    if (w_tick && (r_state != IDLE)) begin
      w_os_nxt = (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_shreg_nxt = w_shreg_load;
          w_os_nxt    = '0;
          w_bit_nxt   = '0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shreg_nxt = r_shreg >> 1;
          w_bit_nxt   = r_bit_idx + BIT_IDX_W'(1);
          if (r_bit_idx == LAST_IDX) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level follows the state being entered so tx stays registered.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_idx <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign st    = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with TICK_LIMIT=3 (64 clks per bit).
module tb_uart_tx;

  localparam int unsigned TL       = 3;
  localparam int          BIT_CLKS = 16 * (TL + 1);
  localparam int          START_TMO = 200;

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] order;  // data bits written in transmission order, left first
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       send;
  logic       ready, tx, busy, done;
  logic [1:0] st;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.TICK_LIMIT(TL)) dut (
    .clk    (clk),
    .reset  (reset),
    .data_in(data_in),
    .send   (send),
    .ready  (ready),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .st     (st)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame from the byte: start, LSB-first data, optional even parity, stop.
  function automatic bitq_t model_frame(input logic [7:0] b);
    bitq_t q;
    int    ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(bit'((b >> i) & 8'd1));
      ones += int'((b >> i) & 8'd1);
    end
`ifdef UART_TX_PARITY_EN
    q.push_back(bit'(ones % 2));
`endif
    q.push_back(1'b1);
    return q;
  endfunction

  function automatic bitq_t vec_frame(input vec_t v);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 7; i >= 0; i--) q.push_back(v.order[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(v.par);
`endif
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    send    = 1'b1;
    step();
    send    = 1'b0;
  endtask

  // Waits for the start edge, then checks every bit boundary, midpoint and the done pulse.
  task automatic check_frame(input bitq_t exp, input string tag, output int waited);
    int nclk;
    int dones;
    waited = 0;
    while (tx !== 1'b0 && waited < START_TMO) begin
      step();
      waited++;
    end
    chk({tag, "_start"}, tx, 0);
    if (tx !== 1'b0) return;
    nclk  = exp.size() * BIT_CLKS;
    dones = 0;
    for (int n = 0; n < nclk; n++) begin
      if ((n % BIT_CLKS) == 0 || (n % BIT_CLKS) == BIT_CLKS / 2 || (n % BIT_CLKS) == BIT_CLKS - 1)
        chk($sformatf("%s_bit%0d_c%0d", tag, n / BIT_CLKS, n % BIT_CLKS), tx, exp[n / BIT_CLKS]);
      if (n == BIT_CLKS / 2) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready_low"}, ready, 0);
      end
      if (done === 1'b1) dones++;
      step();
    end
    chk({tag, "_early_done"}, dones, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready_back"}, ready, 1);
    chk({tag, "_st_idle"}, st, 0);
  endtask

  // Counts tx lows and done pulses over a quiet window.
  task automatic quiet(input int ncyc, input string tag);
    int lows;
    int dones;
    lows  = 0;
    dones = 0;
    for (int n = 0; n < ncyc; n++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (done !== 1'b0) dones++;
    end
    chk({tag, "_tx_quiet"}, lows, 0);
    chk({tag, "_no_done"}, dones, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[8];
    bitq_t q;
    int    w;
    int    toggles;
    logic  prev;

    tbl[0] = '{data: 8'h55, order: 8'b1010_1010, par: 1'b0};
    tbl[1] = '{data: 8'hA3, order: 8'b1100_0101, par: 1'b0};
    tbl[2] = '{data: 8'h0F, order: 8'b1111_0000, par: 1'b0};
    tbl[3] = '{data: 8'h81, order: 8'b1000_0001, par: 1'b0};
    tbl[4] = '{data: 8'h07, order: 8'b1110_0000, par: 1'b1};
    tbl[5] = '{data: 8'hFF, order: 8'b1111_1111, par: 1'b0};
    tbl[6] = '{data: 8'h5A, order: 8'b0101_1010, par: 1'b0};
    tbl[7] = '{data: 8'h00, order: 8'b0000_0000, par: 1'b0};

    reset   = 1'b1;
    send    = 1'b0;
    data_in = 8'h00;
    repeat (5) step();
    chk("rst_ready_held", ready, 0);
    chk("rst_tx_held", tx, 1);
    reset = 1'b0;
    step();
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_st", st, 0);

    toggles = 0;
    prev    = tx;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (tx !== prev) toggles++;
      prev = tx;
    end
    chk("idle_toggles", toggles, 0);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      q = vec_frame(tbl[i]);
      send_byte(tbl[i].data);
      chk($sformatf("tbl%0d_latency", i), tx, 0);
      check_frame(q, $sformatf("tbl%0d", i), w);
      chk($sformatf("tbl%0d_wait", i), w, 0);
      repeat (3) step();
    end

    // Back-to-back with send held and data_in changed mid-frame.
    data_in = 8'hA3;
    send    = 1'b1;
    step();
    fork
      check_frame(vec_frame(tbl[1]), "b2b1", w);
      begin
        repeat (100) step();
        data_in = 8'hFF;
      end
    join
    fork
      check_frame(vec_frame(tbl[5]), "b2b2", w);
      begin
        step();
        step();
        send = 1'b0;
      end
    join
    chk("b2b_gap", w, 1);
    quiet(200, "b2b_after");

    // send pulsed while busy must be dropped.
    send_byte(8'h5A);
    fork
      check_frame(vec_frame(tbl[6]), "busy_send", w);
      begin
        repeat (150) step();
        data_in = 8'h00;
        send    = 1'b1;
        step();
        send    = 1'b0;
      end
    join
    quiet(800, "busy_after");

    // Reset in the middle of data bit 3.
    send_byte(8'h0F);
    repeat (4 * BIT_CLKS + 20) step();
    chk("midrst_st_data", st, 2);
    reset = 1'b1;
    step();
    chk("midrst_tx", tx, 1);
    chk("midrst_st", st, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", ready, 0);
    step();
    reset = 1'b0;
    step();
    chk("midrst_ready_rel", ready, 1);
    chk("midrst_busy_rel", busy, 0);
    quiet(700, "midrst_after");
    send_byte(8'h81);
    check_frame(model_frame(8'h81), "post_rst", w);

    // Randomized bytes, gaps, send hold lengths and post-accept data churn.
    for (int r = 0; r < 6; r++) begin
      logic [7:0] b;
      int         hold;
      b    = 8'($urandom);
      hold = int'($urandom_range(1, 4));
      repeat ($urandom_range(1, 20)) step();
      data_in = b;
      send    = 1'b1;
      step();
      fork
        check_frame(model_frame(b), $sformatf("rnd%0d_%02h", r, b), w);
        begin
          repeat (hold - 1) step();
          send    = 1'b0;
          data_in = 8'($urandom);
        end
      join
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter that serialises one byte per request onto line `tx`.
- Idle-high line; LSB first; one start bit, 8 data bits, one stop bit.
- Bit timing uses 16 ticks per bit, each tick one pulse of an internal tick generator; the default `TICK_LIMIT` gives about 9600 baud at 100 MHz.
- Sits beside the UART receiver and is the transmit half of the same serial link.

Parameters:
- TICK_LIMIT, 650, tick generator terminal count; tick period = TICK_LIMIT+1 clk cycles.
- OVERSAMPLE, 16, ticks per bit period.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  in  1  system clock; everything clocked on posedge clk.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_BITS  byte to send; sampled only on accept.
- send  in  1  request strobe/level; accepted when send=1 and ready=1 on a clk edge.
- ready  out  1  high only in IDLE (not during reset).
- tx  out  1  serial line, registered.
- busy  out  1  equals ~ready.
- done  out  1  one-clk pulse when the stop bit completes.
- st  out  2  current state encoding, for debug.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports named clk and reset).
- Reset values:
  - tx=1, ready=1 after reset deasserts (0 while reset is held), busy=0, done=0, st=2'b00.
  - All counters and the shift register are 0.
- States: IDLE=00, START=01, DATA=10, STOP=11.
- IDLE:
  - tx=1, ready=1.
  - On accept, latch data_in into the shift register, clear the tick and oversample counters, and go to START.
  - tx goes low on the clk edge after accept (1 clk latency).
- Tick generator:
  - Counter runs 0..TICK_LIMIT, tick=1 for one clk when the count equals TICK_LIMIT, then wraps to 0.
  - The counter is synchronously cleared on accept, so every bit lasts exactly OVERSAMPLE*(TICK_LIMIT+1) clks.
- START:
  - tx=0.
  - After 16 ticks (oversample count 15 on a tick), go to DATA with bit index 0.
- DATA:
  - tx = shreg[0].
  - On the 16th tick of each bit, shift right and increment the bit index.
  - After bit index DATA_BITS-1 completes, go to STOP.
- STOP:
  - tx=1.
  - After 16 ticks, go to IDLE and assert done for exactly that one clk.
- Width rules:
  - Tick counter is $clog2(TICK_LIMIT+1) bits.
  - Oversample counter is 4 bits and wraps 15 to 0.
  - Bit index is 4 bits.
- Frame length: 10 bit periods from the first low clk to the return to IDLE.
- send while busy is ignored, with no queueing.
- data_in changes after accept have no effect.
- Back-to-back: if send is held high, the next accept happens on the first IDLE clk, so the inter-frame high is stop bit plus 1 clk.
- Reset mid-frame:
  - tx=1 on the next edge, state goes to IDLE, and the frame is dropped.
  - No done pulse is generated.
- A tick coinciding with accept is ignored, because the counter is cleared.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - After the last data bit, DATA sends one extra bit: the even-parity bit, which is the XOR of the latched byte.
  - The bit index runs to DATA_BITS. Frame = 11 bit periods.
  - st encoding is unchanged.
- Undefined: 8N1 only, with no parity logic synthesised.

Decomposition:
- Package uart_pkg:
  - state localparams IDLE/START/DATA/STOP;
  - OVERSAMPLE=16 default;
  - DATA_BITS default, shared with the receiver.
- Sub-module uart_tx_tick_gen:
  - ports clk, reset, clear, tick; parameter TICK_LIMIT;
  - synchronous clear and reset.

Test Plan (TICK_LIMIT=3, so bit period = 64 clks):
1. Hold reset 5 clks, then release → tx=1, ready=1, busy=0, done=0, st=00. No tx toggles over 2000 clks with send=0.
2. Send 0x55 for 1 clk → tx low 1 clk after accept. Per 64-clk window: 0,1,0,1,0,1,0,1,0,1. done pulses once, 640 clks after tx falls; ready returns high the same clk.
3. Send 0xA3 with send held high and data_in changed to 0xFF mid-frame → first frame bits 1,1,0,0,0,1,0,1. Second frame (0xFF) starts exactly 1 clk after the first returns to IDLE.
4. Pulse send with 0x00 during DATA of a 0x5A frame → 0x5A frame is unaffected; no second frame; one done pulse total.
5. Assert reset during bit index 3 of 0x0F → next edge tx=1, st=00, no done. After release, ready=1 and a new 0x81 frame is correct.
6. With UART_TX_PARITY_EN, send 0x07 → parity bit=1. Frame is 704 clks, stop bit high; loopback into the team UART receiver (same TICK_LIMIT) yields 0x07.
